// File: rtl/idli_pkg.sv
// rtl/idli_pkg.sv - shared idli types; SQI controller states, commands and pin types.
// IDLI_SQI_STREAM_EN adds the HOLD state used by streaming reads.
package idli_pkg;

  localparam int SQI_NUM = 2;

  typedef enum logic {
    SQI_MEM_LO = 1'b0,
    SQI_MEM_HI = 1'b1
  } sqi_mem_t;

  typedef logic [3:0]  sqi_data_t;
  typedef logic [15:0] sqi_word_t;

  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    SQI_IDLE  = 3'd0,
    SQI_CMD   = 3'd1,
    SQI_ADDR  = 3'd2,
    SQI_DUMMY = 3'd3,
    SQI_DATA  = 3'd4,
    SQI_END   = 3'd5
`ifdef IDLI_SQI_STREAM_EN
    , SQI_HOLD = 3'd6
`endif
  } sqi_state_t;

endpackage

// File: rtl/idli_sqi_word_ser.sv
// rtl/idli_sqi_word_ser.sv - 16-bit word to/from two nibble pairs, selected by data-phase index.
module idli_sqi_word_ser
  import idli_pkg::*;
(
  input  logic                      i_idx,
  input  sqi_word_t                 i_tx_word,
  output sqi_data_t [SQI_NUM-1:0]   o_tx_sio,
  input  sqi_data_t [SQI_NUM-1:0]   i_rx_sio,
  input  sqi_word_t                 i_rx_word,
  output sqi_word_t                 o_rx_word
);

  // Phase 0 carries the low byte, phase 1 the high byte; lo memory always holds the low nibble.
  always_comb begin
    o_rx_word = i_rx_word;
    if (i_idx) begin
      o_tx_sio[SQI_MEM_LO] = i_tx_word[11:8];
      o_tx_sio[SQI_MEM_HI] = i_tx_word[15:12];
      o_rx_word[11:8]      = i_rx_sio[SQI_MEM_LO];
      o_rx_word[15:12]     = i_rx_sio[SQI_MEM_HI];
    end else begin
      o_tx_sio[SQI_MEM_LO] = i_tx_word[3:0];
      o_tx_sio[SQI_MEM_HI] = i_tx_word[7:4];
      o_rx_word[3:0]       = i_rx_sio[SQI_MEM_LO];
      o_rx_word[7:4]       = i_rx_sio[SQI_MEM_HI];
    end
  end

endmodule

// File: rtl/idli_sqi_ctrl.sv
// rtl/idli_sqi_ctrl.sv - lock-step sequencer for the lo/hi nibble SQI memories.
// IDLI_SQI_STREAM_EN keeps CS low after reads so a sequential read skips CMD/ADDR/DUMMY.
module idli_sqi_ctrl
  import idli_pkg::*;
#(
  parameter int DUMMY_CYC = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_req_vld,
  output logic                      o_req_rdy,
  input  logic                      i_req_wr,
  input  logic [15:0]               i_req_addr,
  input  logic [15:0]               i_req_data,
  output logic                      o_rd_vld,
  output logic [15:0]               o_rd_data,
  output logic                      o_sqi_sck_en,
  output logic                      o_sqi_cs_n,
  output logic                      o_sqi_oe,
  output sqi_data_t [SQI_NUM-1:0]   o_sqi_sio,
  input  sqi_data_t [SQI_NUM-1:0]   i_sqi_sio
);

  sqi_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       wr_q, wr_d;
  sqi_word_t  addr_q, addr_d;
  sqi_word_t  wdata_q, wdata_d;
  sqi_word_t  rx_q, rx_d;
  sqi_word_t  rd_data_q, rd_data_d;
  logic       rd_vld_q, rd_vld_d;
`ifdef IDLI_SQI_STREAM_EN
  logic       pend_q, pend_d;
`endif

  sqi_data_t [SQI_NUM-1:0] ser_tx;
  sqi_word_t               ser_rx;
  logic [7:0]              cmd;
  sqi_data_t               addr_nib;
  logic                    acc;

  idli_sqi_word_ser u_ser (
    .i_idx     (cnt_q[0]),
    .i_tx_word (wdata_q),
    .o_tx_sio  (ser_tx),
    .i_rx_sio  (i_sqi_sio),
    .i_rx_word (rx_q),
    .o_rx_word (ser_rx)
  );

  assign cmd       = wr_q ? SQI_CMD_WRITE : SQI_CMD_READ;
  assign acc       = i_req_vld & o_req_rdy;
  assign o_rd_vld  = rd_vld_q;
  assign o_rd_data = rd_data_q;

  always_comb begin
    case (cnt_q[1:0])
      2'd0:    addr_nib = addr_q[15:12];
      2'd1:    addr_nib = addr_q[11:8];
      2'd2:    addr_nib = addr_q[7:4];
      default: addr_nib = addr_q[3:0];
    endcase
  end

  // Pin outputs are a pure decode of the state so reset forces them instantly.
  always_comb begin
    o_req_rdy    = 1'b0;
    o_sqi_cs_n   = 1'b1;
    o_sqi_sck_en = 1'b0;
    o_sqi_oe     = 1'b0;
    o_sqi_sio    = '0;
    case (state_q)
      SQI_IDLE: o_req_rdy = ~i_rst;
      SQI_CMD: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = 1'b1;
        o_sqi_oe     = 1'b1;
        o_sqi_sio    = {SQI_NUM{cnt_q[0] ? cmd[3:0] : cmd[7:4]}};
      end
      SQI_ADDR: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = 1'b1;
        o_sqi_oe     = 1'b1;
        o_sqi_sio    = {SQI_NUM{addr_nib}};
      end
      SQI_DUMMY: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = 1'b1;
      end
      SQI_DATA: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = 1'b1;
        o_sqi_oe     = wr_q;
        if (wr_q) o_sqi_sio = ser_tx;
      end
`ifdef IDLI_SQI_STREAM_EN
      SQI_HOLD: begin
        o_req_rdy  = ~i_rst;
        o_sqi_cs_n = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
    rd_vld_d  = 1'b0;
`ifdef IDLI_SQI_STREAM_EN
    pend_d    = pend_q;
`endif
    if (acc) begin
      wr_d    = i_req_wr;
      addr_d  = i_req_addr;
      wdata_d = i_req_data;
    end
    case (state_q)
      SQI_IDLE: begin
        if (acc) begin
          state_d = SQI_CMD;
          cnt_d   = 3'd0;
        end
      end
      SQI_CMD: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q[0]) begin
          state_d = SQI_ADDR;
          cnt_d   = 3'd0;
        end
      end
      SQI_ADDR: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd3) begin
          state_d = wr_q ? SQI_DATA : SQI_DUMMY;
          cnt_d   = 3'd0;
        end
      end
      SQI_DUMMY: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(DUMMY_CYC - 1)) begin
          state_d = SQI_DATA;
          cnt_d   = 3'd0;
        end
      end
      SQI_DATA: begin
        cnt_d = cnt_q + 3'd1;
        if (!wr_q) rx_d = ser_rx;
        if (cnt_q[0]) begin
          cnt_d   = 3'd0;
          state_d = SQI_END;
          if (!wr_q) begin
            rd_data_d = ser_rx;
            rd_vld_d  = 1'b1;
`ifdef IDLI_SQI_STREAM_EN
            state_d   = SQI_HOLD;
`endif
          end
        end
      end
      SQI_END: begin
        state_d = SQI_IDLE;
`ifdef IDLI_SQI_STREAM_EN
        if (pend_q) begin
          state_d = SQI_CMD;
          cnt_d   = 3'd0;
          pend_d  = 1'b0;
        end
`endif
      end
`ifdef IDLI_SQI_STREAM_EN
      // HOLD is only entered after a read, so addr_q is still that read's address.
      SQI_HOLD: begin
        if (acc) begin
          cnt_d = 3'd0;
          if (!i_req_wr && (i_req_addr == addr_q + 16'd1)) begin
            state_d = SQI_DATA;
          end else begin
            state_d = SQI_END;
            pend_d  = 1'b1;
          end
        end
      end
`endif
      default: state_d = SQI_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= SQI_IDLE;
      cnt_q     <= 3'd0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
`ifdef IDLI_SQI_STREAM_EN
      pend_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
`ifdef IDLI_SQI_STREAM_EN
      pend_q    <= pend_d;
`endif
    end
  end

endmodule

// File: doc/idli_sqi_ctrl.md
# idli_sqi_ctrl

Sequencer for the two SQI memories (low-nibble and high-nibble) that hold idli program and data storage. It accepts one 16-bit word read or write request at a time and drives both memories in lock-step through the command, address, dummy and data phases. It returns read words to the core as a single registered 16-bit value. The block sits between the core's fetch/load-store logic and the SQI pins.

## Interface
- DUMMY_CYC, 2, read dummy phase length in cycles (2 = one dummy byte).
- i_clk  in  1  core clock, shared with the SQI memories through o_sqi_sck_en.
- i_rst  in  1  asynchronous, active-high reset.
- i_req_vld  in  1  request valid.
- o_req_rdy  out  1  request accepted when i_req_vld & o_req_rdy.
- i_req_wr  in  1  1 = write, 0 = read.
- i_req_addr  in  16  word address; the same byte address is sent to both memories.
- i_req_data  in  16  write data, sampled at accept.
- o_rd_vld  out  1  one-cycle pulse; o_rd_data is valid.
- o_rd_data  out  16  read word.
- o_sqi_sck_en  out  1  memory clock enable; the board gates i_clk with it.
- o_sqi_cs_n  out  1  chip select, shared by both memories, active low.
- o_sqi_oe  out  1  1 = controller drives the SIO pins.
- o_sqi_sio  out  SQI_NUM x 4  nibble to each memory, indexed by sqi_mem_t.
- i_sqi_sio  in  SQI_NUM x 4  nibble from each memory.

## Operation
- States: IDLE, CMD, ADDR, DUMMY, DATA, END, plus HOLD when IDLI_SQI_STREAM_EN is defined. A 3-bit counter indexes the nibble within the current phase.
- Reset values:
  - o_sqi_cs_n=1.
  - o_sqi_sck_en=0, o_sqi_oe=0, o_sqi_sio=0.
  - o_req_rdy=0 during reset, then 1 in the first IDLE cycle.
  - o_rd_vld=0, o_rd_data=0.
- IDLE: o_req_rdy=1. On accept, latch wr, addr and data, then go to CMD.
- CMD (2 cycles): both memories receive the same command byte, high nibble first. Read uses SQI_CMD_READ=0x03; write uses SQI_CMD_WRITE=0x02. o_sqi_oe=1.
- ADDR (4 cycles): addr[15:12], [11:8], [7:4], [3:0] to both memories. o_sqi_oe=1.
- DUMMY (DUMMY_CYC cycles, reads only): o_sqi_oe=0; SIO is ignored.
- DATA (2 cycles):
  - Cycle D0: lo memory ↔ word[3:0], hi memory ↔ word[7:4].
  - Cycle D1: lo memory ↔ word[11:8], hi memory ↔ word[15:12].
  - Write: o_sqi_oe=1. Read: o_sqi_oe=0, and i_sqi_sio is sampled at the end of each cycle.
- END (1 cycle): o_sqi_cs_n=1, o_sqi_sck_en=0. Then go to IDLE.
- o_sqi_cs_n=0 and o_sqi_sck_en=1 in CMD, ADDR, DUMMY and DATA. o_sqi_sck_en=0 in every other state.
- o_rd_vld pulses for exactly one cycle, the cycle after read D1. o_rd_data holds its value until the next read completes.
- Reset mid-transaction: the controller returns to IDLE immediately and deasserts CS. The transfer is abandoned; no o_rd_vld is produced.
- Request inputs are ignored whenever o_req_rdy=0.

## Timing
- Read accepted in cycle 0:
  - CMD 1–2, ADDR 3–4–5–6, DUMMY 7–8, DATA 9–10.
  - o_rd_vld=1 in cycle 11, which is also END.
  - o_req_rdy=1 in cycle 12.
- Write accepted in cycle 0:
  - CMD 1–2, ADDR 3–6, DATA 7–8, END 9.
  - o_req_rdy=1 in cycle 10.
- Back-to-back requests: minimum CS-high time is 1 cycle (END).

## Configuration
- IDLI_SQI_STREAM_EN defined:
  - After a read's DATA phase, go to HOLD instead of END. In HOLD: CS stays low, sck_en=0, o_req_rdy=1.
  - A read with addr == last_addr+1 (16-bit wrap: 0xFFFF→0x0000) goes straight to DATA. o_rd_vld follows 3 cycles after accept.
  - Any other accepted request passes through END (1 cycle), then to CMD with the latched request.
  - Idle HOLD persists indefinitely.
- Not defined: HOLD does not exist, and every transaction is a full CMD/ADDR/(DUMMY)/DATA/END sequence.

## Structure
- Add to idli_pkg:
  - sqi_state_t enum.
  - SQI_CMD_READ and SQI_CMD_WRITE localparams (8-bit).
  - sqi_word_t (logic [15:0]).
- Existing sqi_mem_t, sqi_data_t and SQI_NUM index the pin arrays.
- One sub-module: idli_sqi_word_ser. It is a 16-bit word ↔ 2x(2 nibble) serialiser/deserialiser selected by a data-phase index.

## Test plan
- Read addr 0x1234; memory model returns lo=0xD,0xB and hi=0xC,0xA:
  - SIO shows 0,3 then 1,2,3,4, then 2 dummy cycles.
  - o_rd_vld in cycle 11 with o_rd_data=0xABCD.
- Write addr 0x0010, data 0x5A3C:
  - Command nibbles 0,2.
  - lo memory receives C,A; hi memory receives 3,5.
  - CS rises in cycle 9; o_req_rdy=1 in cycle 10.
- Assert i_rst in read cycle 5:
  - Outputs go to reset values asynchronously.
  - No o_rd_vld; the next read completes normally.
- Continuous back-to-back reads/writes with i_req_vld held high:
  - Each accept only when o_req_rdy=1.
  - CS high exactly 1 cycle between transactions.
- IDLI_SQI_STREAM_EN: read 0xFFFF, then read 0x0000:
  - The second read has no CMD or ADDR phase; o_rd_vld 3 cycles after accept.
- IDLI_SQI_STREAM_EN: read 0x0100, then read 0x0200:
  - END, then a full sequence; o_rd_vld 12 cycles after the second accept.
